// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word intake handshake plus serial bit stream of the serializer
// Signals: data_in/data_valid/data_ready (word handshake), d/d_valid/d_last (serial stream).
// Modports: master = upstream/observer side, slave = serializer side.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             d;
    logic             d_valid;
    logic             d_last;
    modport master (output data_in, data_valid, input data_ready, d, d_valid, d_last);
    modport slave  (input data_in, data_valid, output data_ready, d, d_valid, d_last);
endinterface

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel words in over valid/ready, gapless registered bitstream out
// Optional feature macro: SEQ_SER_PARITY_EN appends an even-parity bit to every frame.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - slave modport: data_in/data_valid in, data_ready out (from state only),
//           d/d_valid/d_last out (registered)
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    seq_bit_serializer_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_nxt;
    logic             d_q, d_d, d_valid_q, d_valid_d, d_last_q, d_last_d, accept;
`ifdef SEQ_SER_PARITY_EN
    logic             par_q, par_d;
`endif
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction
    // A new word may enter while idle or while the final bit of a frame is on the wire.
    assign bus.data_ready = !reset && (state_q == IDLE || d_last_q);
    assign accept         = bus.data_valid && bus.data_ready;
    // The register head always equals the bit currently driven on d.
    assign sh_nxt         = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        d_d       = d_q;
        d_valid_d = d_valid_q;
        d_last_d  = d_last_q;
`ifdef SEQ_SER_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q == SHIFT && cnt_q != LAST) begin
            cnt_d    = cnt_q + 1'b1;
            sh_d     = sh_nxt;
            d_d      = head(sh_nxt);
`ifdef SEQ_SER_PARITY_EN
            d_last_d = 1'b0;
`else
            d_last_d = cnt_q == LAST - 1'b1;
`endif
        end
`ifdef SEQ_SER_PARITY_EN
        else if (state_q == SHIFT) begin
            state_d  = PARITY;
            d_d      = par_q;
            d_last_d = 1'b1;
        end
`endif
        else if (accept) begin
            state_d   = SHIFT;
            cnt_d     = '0;
            sh_d      = bus.data_in;
            d_d       = head(bus.data_in);
            d_valid_d = 1'b1;
            d_last_d  = 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_d     = ^bus.data_in;
`endif
        end
        else begin
            state_d   = IDLE;
            cnt_d     = '0;
            d_d       = IDLE_BIT;
            d_valid_d = 1'b0;
            d_last_d  = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            d_q       <= IDLE_BIT;
            d_valid_q <= 1'b0;
            d_last_q  <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
            d_last_q  <= d_last_d;
`ifdef SEQ_SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end
    assign bus.d       = d_q;
    assign bus.d_valid = d_valid_q;
    assign bus.d_last  = d_last_q;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: two serializer configurations checked against a bit-queue model and a directed table
module tb_seq_bit_serializer;
`ifdef SEQ_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 8 + PAR;
    typedef struct {
        logic [7:0] w;
        bit         gap;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       p;
    } tv_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] din = 8'h00;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    seq_bit_serializer_if #(.WIDTH(8)) ia ();
    seq_bit_serializer_if #(.WIDTH(8)) ib ();
    assign ia.data_in    = din;
    assign ia.data_valid = vld;
    assign ib.data_in    = din;
    assign ib.data_valid = vld;
    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ib));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
    task automatic chk(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", n, act, exp, $time);
        end
    endtask
    // Emission order of one frame: index 0 goes out first, index 8 is the parity bit.
    function automatic logic [8:0] frame(input logic [7:0] w, input bit msb);
        logic [8:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i] = msb ? w[7-i] : w[i];
        f[8] = ^w;
        return f;
    endfunction
    // One clock: drive inputs, check ready, advance model, check registered outputs at negedge.
    task automatic tick(input logic v, input logic [7:0] w);
        logic       r;
        logic [8:0] fa, fb;
        vld = v;
        din = w;
        r = qa.size() == 0 || qa[0][1];
        chk("ready_a", ia.data_ready, r);
        chk("ready_b", ib.data_ready, r);
        @(posedge clk);
        if (qa.size() != 0) qa.delete(0);
        if (qb.size() != 0) qb.delete(0);
        if (v && r) begin
            fa = frame(w, 1'b1);
            fb = frame(w, 1'b0);
            for (int i = 0; i < FL; i++) begin
                qa.push_back({i == FL - 1, fa[i]});
                qb.push_back({i == FL - 1, fb[i]});
            end
        end
        @(negedge clk);
        chk("d_a", ia.d, qa.size() != 0 ? qa[0][0] : 1'b0);
        chk("dv_a", ia.d_valid, qa.size() != 0);
        chk("dl_a", ia.d_last, qa.size() != 0 ? qa[0][1] : 1'b0);
        chk("d_b", ib.d, qb.size() != 0 ? qb[0][0] : 1'b1);
        chk("dv_b", ib.d_valid, qb.size() != 0);
        chk("dl_b", ib.d_last, qb.size() != 0 ? qb[0][1] : 1'b0);
    endtask
    // Directed frame: compare each emitted bit against hand-derived table patterns.
    task automatic send(input tv_t t);
        tick(1'b1, t.w);
        for (int i = 0; i < FL; i++) begin
            chk("tbl_dv_a", ia.d_valid, 1'b1);
            chk("tbl_dv_b", ib.d_valid, 1'b1);
            chk("tbl_last_a", ia.d_last, i == FL - 1);
            chk("tbl_last_b", ib.d_last, i == FL - 1);
            chk("tbl_bit_a", ia.d, i < 8 ? t.ea[7-i] : t.p);
            chk("tbl_bit_b", ib.d, i < 8 ? t.eb[7-i] : t.p);
            if (i < FL - 1) tick(1'($urandom_range(0, 1)), 8'($urandom));
        end
        if (t.gap) begin
            tick(1'b0, 8'h00);
            chk("tbl_idle_d_a", ia.d, 1'b0);
            chk("tbl_idle_dv_a", ia.d_valid, 1'b0);
            chk("tbl_idle_d_b", ib.d, 1'b1);
            chk("tbl_idle_dv_b", ib.d_valid, 1'b0);
        end
    endtask
    initial begin
        tv_t tbl[5];
        tbl[0] = '{8'hA5, 1'b1, 8'b10100101, 8'b10100101, 1'b0};
        tbl[1] = '{8'h05, 1'b0, 8'b00000101, 8'b10100000, 1'b0};
        tbl[2] = '{8'h80, 1'b1, 8'b10000000, 8'b00000001, 1'b1};
        tbl[3] = '{8'h0D, 1'b1, 8'b00001101, 8'b10110000, 1'b1};
        tbl[4] = '{8'h07, 1'b1, 8'b00000111, 8'b11100000, 1'b1};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_d_a", ia.d, 1'b0);
        chk("rst_d_b", ib.d, 1'b1);
        chk("rst_dv_a", ia.d_valid, 1'b0);
        chk("rst_dl_a", ia.d_last, 1'b0);
        chk("rst_ready_a", ia.data_ready, 1'b0);
        chk("rst_ready_b", ib.data_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_ready_a", ia.data_ready, 1'b1);
        chk("rel_ready_b", ib.data_ready, 1'b1);
        repeat (20) tick(1'b0, 8'($urandom));
        for (int e = 0; e < 5; e++) send(tbl[e]);
        tick(1'b1, 8'hFF);
        repeat (3) tick(1'b0, 8'h00);
        #2 reset = 1'b1;
        #1;
        chk("arst_d_a", ia.d, 1'b0);
        chk("arst_dv_a", ia.d_valid, 1'b0);
        chk("arst_dl_a", ia.d_last, 1'b0);
        chk("arst_d_b", ib.d, 1'b1);
        chk("arst_dv_b", ib.d_valid, 1'b0);
        chk("arst_ready_a", ia.data_ready, 1'b0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arel_ready_a", ia.data_ready, 1'b1);
        chk("arel_ready_b", ib.data_ready, 1'b1);
        send('{8'h01, 1'b1, 8'b00000001, 8'b10000000, 1'b1});
        repeat (300) tick(1'($urandom_range(0, 3) != 0), 8'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Upstream feeder for the serial sequence-detector stage. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single-bit stream (`d`, `d_valid`). Back-to-back words produce a gapless bitstream. When no word is in flight, the output holds a fixed idle level, so the downstream stage, which samples `d` every cycle, sees a defined value.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2–32.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `d` whenever `d_valid` is 0.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `data_in`, input, WIDTH: parallel word; sampled only on a handshake.
- `data_valid`, input, 1: upstream word available.
- `data_ready`, output, 1: block can accept a word this cycle.
- `d`, output, 1: serial bit, registered.
- `d_valid`, output, 1: `d` carries a data or parity bit, registered.
- `d_last`, output, 1: current `d` is the final bit of a frame, registered.

## Operation
- **Handshake:** a word is accepted on a rising edge where `data_valid && data_ready`. The word is copied into the shift register; `data_in` is ignored otherwise.
- **`data_ready`:** `data_ready = (state == IDLE) || d_last`.
  - It is a function of state only, never of `data_valid`.
  - It is 0 while `reset` is asserted.
- **States:**
  - IDLE → SHIFT on accept.
  - SHIFT: the bit counter runs 0..WIDTH-1.
  - On the last data bit, next state is:
    - PARITY, if the macro is enabled.
    - SHIFT with a fresh word and counter 0, if accepted this cycle.
    - IDLE, otherwise.
  - PARITY: lasts one cycle; next state is SHIFT on accept, else IDLE.
- **Output:**
  - In SHIFT, `d` equals the shift-register head bit and `d_valid = 1`.
  - In IDLE, `d = IDLE_BIT` and `d_valid = 0`.
- **`d_last`:** 1 on the final bit of each frame. This is data bit WIDTH-1, or the parity bit when the macro is enabled.
- **Bit counter:** `$clog2(WIDTH+1)` bits wide; no wrap beyond the frame length.
- **Reset values:**
  - `d = IDLE_BIT`, `d_valid = 0`, `d_last = 0`.
  - State IDLE; counter 0; shift register 0.
- **Reset mid-frame:** the frame is aborted immediately (asynchronous). Remaining bits are discarded and never emitted. After release, `data_ready = 1` in the first cycle.
- **Simultaneous events:**
  - Accept on a `d_last` cycle: the next frame's first bit appears the next cycle with no idle gap.
  - `data_valid` dropping mid-frame has no effect on the frame in flight.

## Timing
- **Latency:** a word accepted at edge N drives its first bit at edges N+1 through N+1 (valid until edge N+2). Bit k is valid in the cycle after edge N+1+k.
- **Frame length:** WIDTH cycles, or WIDTH+1 cycles with parity.
- **Throughput:** with `data_valid` held high, one word per frame length, and `d_valid` stays continuously 1.
- **Registered outputs:** all outputs except `data_ready` are registered. `data_ready` is combinational from state registers only.

## Configuration
- **Macro:** `SEQ_SER_PARITY_EN`.
- **Defined:**
  - The PARITY state is compiled in.
  - After each word, one extra bit equal to the even parity (XOR of all WIDTH bits) is emitted with `d_valid = 1`.
  - `d_last` marks the parity bit; the frame is WIDTH+1 cycles.
- **Undefined:**
  - No PARITY state and no parity logic.
  - The frame is exactly WIDTH bits; `d_last` marks data bit WIDTH-1.

## Test plan
- **Single word, MSB-first:** WIDTH=8, MSB_FIRST=1, accept 8'hA5 at edge 0.
  - `d` = 1,0,1,0,0,1,0,1 after edges 1–8.
  - `d_valid` is high 8 cycles; `d_last` is high only after edge 8.
  - After edge 9: `d = 0`, `d_valid = 0`.
- **Back-to-back, gapless:** `data_valid` held high with 8'h05 then 8'h80.
  - 16 consecutive valid bits: 00000101 10000000.
  - `data_ready` is high only in IDLE and on the two `d_last` cycles.
- **LSB-first, non-default idle level:** MSB_FIRST=0, IDLE_BIT=1, accept 8'h0D.
  - `d` = 1,0,1,1,0,0,0,0.
  - `d = 1` with `d_valid = 0` before and after the frame.
- **Reset mid-frame:** assert `reset` asynchronously during bit 3 of 8'hFF.
  - `d_valid` and `d_last` drop to 0 and `d` goes to IDLE_BIT without waiting for a clock edge.
  - After release, `data_ready = 1`; a new word 8'h01 emits exactly 8 bits.
- **Parity (SEQ_SER_PARITY_EN):** 8'hA5 then 8'h07.
  - 9th bits are 0 and 1 respectively.
  - `d_last` is on the parity bits; 18 consecutive valid cycles.
- **Backpressure-free idle:** `data_valid` low for 20 cycles after reset.
  - `d_valid = 0`, `d = IDLE_BIT`, `data_ready = 1` throughout.
